spi_master: RTL and testbench
=============================

# spi_master

Single-clock SPI initiator that drives the command/data frames consumed by `spi_slave` and its single-port RAM, and collects read-back bytes on MISO. It sits between a host-side command interface (valid/ready) and the four SPI wires, running in the same `clk` domain as the slave. It handles frame sequencing, the slave's command-check cycle, read-latency alignment and the inter-frame gap.

## Interface
Parameters:
- `RD_LAT`, default 3: cycles from the last MOSI bit cycle to the first MISO sample cycle (≥1).
- `GAP`, default 1: cycles SS_n is held high after each frame (≥1).

Ports:
- `clk`  in  1  rising-edge clock shared with the slave. One clock only.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `cmd_valid`  in  1  host offers a frame.
- `cmd_data`  in  10  frame; [9:8] = opcode (00 WR_ADDR, 01 WR_DATA, 10 RD_ADDR, 11 RD_DATA), [7:0] = address, data or don't-care.
- `cmd_ready`  out  1  high only in IDLE. Transfer occurs when `cmd_valid && cmd_ready`.
- `rd_valid`  out  1  one-cycle pulse when `rd_data` is updated.
- `rd_data`  out  8  last received byte, MSB first. Holds its value between pulses.
- `busy`  out  1  high in every state except IDLE.
- `SS_n`  out  1  slave select, registered.
- `MOSI`  out  1  serial out, registered.
- `MISO`  in  1  serial in, sampled on `clk` rising edge.

## Operation
- States: IDLE, SEL, CHK, SHIFT, WAIT, RECV, GAP_ST.
- IDLE
  - SS_n=1, MOSI=0.
  - On accept, latch `cmd_data` into a 10-bit shift register and go to SEL.
- SEL
  - Lasts 1 cycle: SS_n=0, MOSI=0.
  - Go to CHK.
- CHK
  - Lasts 1 cycle: MOSI=cmd[9]. This is the slave's command-check bit.
  - Go to SHIFT.
- SHIFT
  - Lasts 10 cycles: MOSI=cmd[9], cmd[8] … cmd[0]. cmd[9] is therefore driven twice.
  - A 4-bit bit counter runs 0..9.
  - Exit is decided by the opcode: opcode 11 → WAIT; otherwise → GAP_ST.
- WAIT
  - Lasts RD_LAT−1 cycles (skipped when RD_LAT=1): SS_n=0, MOSI=0.
  - Go to RECV.
- RECV
  - Lasts 8 cycles: SS_n=0, MOSI=0.
  - MISO is shifted into an 8-bit register at the end of each cycle.
  - After the 8th sample: `rd_data` takes the shifted byte and `rd_valid`=1 for the next cycle. Go to GAP_ST.
- GAP_ST
  - Lasts GAP cycles: SS_n=1, MOSI=0.
  - Go to IDLE.
- Host rules:
  - `cmd_valid` while not ready is ignored; the master does not queue frames.
  - `cmd_data` is sampled only at accept.
- Counter width: the shared counter is max(4, $clog2(max(RD_LAT, GAP))+1) bits. It is reloaded on every state entry and never wraps mid-state.
- The master does not enforce RD_ADDR-before-RD_DATA ordering; this is the host's responsibility.

## Timing
- Cycle numbering: cycle 0 is the first cycle after the accept edge.
  - Cycle 0: SS_n falls.
  - Cycle 1: CHK bit.
  - Cycles 2–11: frame bits.
- Non-read frames:
  - SS_n high in cycles 12..11+GAP.
  - `cmd_ready` is high in cycle 12+GAP.
  - Frame period is 13+GAP cycles.
- RD_DATA frames:
  - MISO sampled at the end of cycles 11+RD_LAT .. 18+RD_LAT.
  - `rd_valid` is high in cycle 19+RD_LAT, coincident with the first GAP_ST cycle.
  - `cmd_ready` returns in cycle 19+RD_LAT+GAP.
- Reset values: SS_n=1, MOSI=0, cmd_ready=1, busy=0, rd_valid=0, rd_data=0. The state is IDLE.
- Reset mid-frame: SS_n goes high asynchronously and the frame is abandoned. No `rd_valid` is produced and `rd_data` is cleared.
- Accept on the same edge that IDLE is entered is not possible, because `cmd_ready` is derived from the registered state.

## Structure
- Shared package `spi_pkg` holds:
  - state enum;
  - opcode constants OP_WR_ADDR=2'b00, OP_WR_DATA=2'b01, OP_RD_ADDR=2'b10, OP_RD_DATA=2'b11;
  - FRAME_W=10 and DATA_W=8.
- One sub-module, `spi_master_shifter`. It holds the loadable 10-bit MSB-first TX shift register and the 8-bit RX shift register, with load, shift and sample enables.
- The FSM and counter stay in `spi_master`.

## Test plan
- WR_ADDR 10'h0A5, GAP=1:
  - MOSI in cycles 1..11 = 0,0,0,1,0,1,0,0,1,0,1.
  - SS_n low in cycles 0..11.
  - `cmd_ready` back in cycle 13.
- RD_DATA with a MISO model driving 0xC3 MSB first from cycle 14 (RD_LAT=3):
  - `rd_data`=0xC3.
  - `rd_valid` is a single pulse in cycle 22.
- Back-to-back with `cmd_valid` held high (WR_ADDR then WR_DATA) and GAP=2:
  - SS_n high for exactly 2 cycles between frames.
  - No accept while busy.
- Assert `rst_n` low in SHIFT cycle 6 of an RD_DATA frame:
  - SS_n=1 immediately.
  - No `rd_valid`, `rd_data`=0.
  - The next frame completes normally.
- Closed loop with `spi_slave` + RAM, using the system RD_LAT:
  - Sequence: WR_ADDR 0x12, WR_DATA 0x5A, RD_ADDR 0x12, RD_DATA.
  - Required result: `rd_data`=0x5A.
- `cmd_valid` pulsed while busy: the pulse is ignored and no extra frame appears on SS_n.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared constants for the SPI master: frame geometry, opcodes and FSM state encodings.
package spi_pkg;

   localparam int FRAME_W = 10;
   localparam int DATA_W  = 8;

   localparam logic [1:0] OP_WR_ADDR = 2'b00;
   localparam logic [1:0] OP_WR_DATA = 2'b01;
   localparam logic [1:0] OP_RD_ADDR = 2'b10;
   localparam logic [1:0] OP_RD_DATA = 2'b11;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE  = 3'd0;
   localparam state_t ST_SEL   = 3'd1;
   localparam state_t ST_CHK   = 3'd2;
   localparam state_t ST_SHIFT = 3'd3;
   localparam state_t ST_WAIT  = 3'd4;
   localparam state_t ST_RECV  = 3'd5;
   localparam state_t ST_GAP   = 3'd6;

endpackage

// File: rtl/spi_master_shifter.sv
// TX (loadable, MSB first) and RX shift registers for the SPI master.
module spi_master_shifter
   import spi_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               load_i,
   input  logic [FRAME_W-1:0] load_data_i,
   input  logic               shift_i,
   input  logic               sample_i,
   input  logic               miso_i,
   output logic               tx_msb_o,
   output logic               tx_next_o,
   output logic [DATA_W-1:0]  rx_next_o
);

   logic [FRAME_W-1:0] tx_q, tx_d;
   logic [DATA_W-1:0]  rx_q, rx_d;
   logic               unused_rx_msb;

   always_comb begin
      tx_d = tx_q;
      if (load_i) begin
         tx_d = load_data_i;
      end else if (shift_i) begin
         tx_d = {tx_q[FRAME_W-2:0], 1'b0};
      end
   end

   // The byte including the bit being sampled now, so the top can capture it on the 8th edge.
   assign rx_next_o     = {rx_q[DATA_W-2:0], miso_i};
   assign rx_d          = sample_i ? rx_next_o : rx_q;
   assign unused_rx_msb = rx_q[DATA_W-1];

   assign tx_msb_o  = tx_q[FRAME_W-1];
   assign tx_next_o = tx_q[FRAME_W-2];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_q <= '0;
         rx_q <= '0;
      end else begin
         tx_q <= tx_d;
         rx_q <= rx_d;
      end
   end

endmodule

// File: rtl/spi_master.sv
// SPI initiator: sends 10-bit command frames with a leading check bit and collects
// read-back bytes on MISO after a fixed read latency.
module spi_master
   import spi_pkg::*;
#(
   parameter int unsigned RD_LAT = 3,
   parameter int unsigned GAP    = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               cmd_valid,
   input  logic [FRAME_W-1:0] cmd_data,
   output logic               cmd_ready,
   output logic               rd_valid,
   output logic [DATA_W-1:0]  rd_data,
   output logic               busy,
   output logic               SS_n,
   output logic               MOSI,
   input  logic               MISO
);

   localparam int unsigned MAX_LEN = (RD_LAT > GAP) ? RD_LAT : GAP;
   localparam int unsigned CNT_W   = ($clog2(MAX_LEN) + 1 > 4) ? $clog2(MAX_LEN) + 1 : 4;

   localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(FRAME_W - 1);
   localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'((RD_LAT > 1) ? RD_LAT - 2 : 0);
   localparam logic [CNT_W-1:0] RECV_LAST  = CNT_W'(DATA_W - 1);
   localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP - 1);

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [1:0]         op_q, op_d;
   logic               ss_n_q, ss_n_d;
   logic               mosi_q, mosi_d;
   logic               rd_valid_q, rd_valid_d;
   logic [DATA_W-1:0]  rd_data_q, rd_data_d;

   logic               accept;
   logic               rx_done;
   logic               tx_msb, tx_next;
   logic [DATA_W-1:0]  rx_next;

   assign accept  = cmd_valid && (state_q == ST_IDLE);
   assign rx_done = (state_q == ST_RECV) && (cnt_q == RECV_LAST);

   spi_master_shifter u_shifter (
      .clk         (clk),
      .rst_n       (rst_n),
      .load_i      (accept),
      .load_data_i (cmd_data),
      .shift_i     (state_q == ST_SHIFT),
      .sample_i    (state_q == ST_RECV),
      .miso_i      (MISO),
      .tx_msb_o    (tx_msb),
      .tx_next_o   (tx_next),
      .rx_next_o   (rx_next)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (accept) state_d = ST_SEL;
         ST_SEL:   state_d = ST_CHK;
         ST_CHK:   state_d = ST_SHIFT;
         ST_SHIFT: begin
            if (cnt_q == SHIFT_LAST) begin
               if (op_q == OP_RD_DATA) state_d = (RD_LAT > 1) ? ST_WAIT : ST_RECV;
               else                    state_d = ST_GAP;
            end
         end
         ST_WAIT:  if (cnt_q == WAIT_LAST) state_d = ST_RECV;
         ST_RECV:  if (cnt_q == RECV_LAST) state_d = ST_GAP;
         ST_GAP:   if (cnt_q == GAP_LAST)  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      // Counter restarts on every state entry and idles at zero.
      cnt_d = ((state_d != state_q) || (state_q == ST_IDLE)) ? '0 : cnt_q + 1'b1;
      op_d  = accept ? cmd_data[FRAME_W-1:FRAME_W-2] : op_q;

      ss_n_d = (state_d == ST_IDLE) || (state_d == ST_GAP);

      // cmd[9] goes out in CHK and again in the first SHIFT cycle; the TX register
      // only shifts while already in SHIFT, hence bit 8 is next from then on.
      mosi_d = 1'b0;
      if (state_d == ST_CHK) begin
         mosi_d = tx_msb;
      end else if (state_d == ST_SHIFT) begin
         mosi_d = (state_q == ST_SHIFT) ? tx_next : tx_msb;
      end

      rd_valid_d = rx_done;
      rd_data_d  = rx_done ? rx_next : rd_data_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         op_q       <= '0;
         ss_n_q     <= 1'b1;
         mosi_q     <= 1'b0;
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         op_q       <= op_d;
         ss_n_q     <= ss_n_d;
         mosi_q     <= mosi_d;
         rd_valid_q <= rd_valid_d;
         rd_data_q  <= rd_data_d;
      end
   end

   assign cmd_ready = (state_q == ST_IDLE);
   assign busy      = (state_q != ST_IDLE);
   assign SS_n      = ss_n_q;
   assign MOSI      = mosi_q;
   assign rd_valid  = rd_valid_q;
   assign rd_data   = rd_data_q;

endmodule

// File: tb/tb_spi_master.sv
// Self-checking bench for spi_master with a behavioural SPI slave + RAM model and
// frame / read-data scoreboards.
module tb_spi_master;
   import spi_pkg::*;

   localparam int RD_LAT = 3;

   logic       clk = 1'b0;
   logic       rst_n;
   int         cyc = 0;
   int         errors = 0;
   int         checks = 0;

   // DUT A: GAP=1, with the slave model on its wires
   logic       cmd_valid, cmd_ready, rd_valid, busy, ss_n, mosi, miso;
   logic [9:0] cmd_data;
   logic [7:0] rd_data;

   // DUT B: GAP=2, used for back-to-back framing
   logic       b_valid, b_ready, b_rd_valid, b_busy, b_ss_n, b_mosi;
   logic [9:0] b_data;
   logic [7:0] b_rd_data;

   logic [9:0] frame_q[$];
   logic [7:0] exp_rd[$];
   int         rv_count = 0;
   logic [7:0] mon_exp;
   logic [9:0] mdl_exp;

   // slave model state
   int         pos;
   logic [10:0] sh;
   logic [7:0] slv_wa, slv_ra, reply;
   logic       rd_pend;
   logic [7:0] slv_mem [256];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   spi_master #(.RD_LAT(RD_LAT), .GAP(1)) dut (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_data(cmd_data),
      .cmd_ready(cmd_ready), .rd_valid(rd_valid), .rd_data(rd_data), .busy(busy),
      .SS_n(ss_n), .MOSI(mosi), .MISO(miso)
   );

   spi_master #(.RD_LAT(RD_LAT), .GAP(2)) dut_b (
      .clk(clk), .rst_n(rst_n), .cmd_valid(b_valid), .cmd_data(b_data),
      .cmd_ready(b_ready), .rd_valid(b_rd_valid), .rd_data(b_rd_data), .busy(b_busy),
      .SS_n(b_ss_n), .MOSI(b_mosi), .MISO(1'b0)
   );

   // Slave + RAM model: check bit, 10 frame bits, read reply RD_LAT cycles after the last bit.
   initial begin
      pos = 0; sh = '0; slv_wa = '0; slv_ra = '0; reply = '0; rd_pend = 1'b0; miso = 1'b0;
      forever begin
         @(negedge clk);
         miso = 1'b0;
         if (ss_n !== 1'b0) begin
            pos = 0;
            rd_pend = 1'b0;
         end else begin
            if (pos >= 1 && pos <= 11) sh = {sh[9:0], mosi};
            if (pos == 11) begin
               checks++;
               if (sh[10] !== sh[9])
                  begin errors++; $display("FAIL chk_bit got=%b need=%b", sh[10], sh[9]); end
               checks++;
               if (frame_q.size() == 0) begin
                  errors++; $display("FAIL unexpected_frame got=%h need=none", sh[9:0]);
               end else begin
                  mdl_exp = frame_q.pop_front();
                  if (sh[9:0] !== mdl_exp)
                     begin errors++; $display("FAIL frame got=%h need=%h", sh[9:0], mdl_exp); end
               end
               case (sh[9:8])
                  OP_WR_ADDR: slv_wa = sh[7:0];
                  OP_WR_DATA: slv_mem[slv_wa] = sh[7:0];
                  OP_RD_ADDR: slv_ra = sh[7:0];
                  default: begin reply = slv_mem[slv_ra]; rd_pend = 1'b1; end
               endcase
            end
            if (rd_pend && pos >= 11 + RD_LAT && pos <= 18 + RD_LAT) miso = reply[18 + RD_LAT - pos];
            pos++;
         end
      end
   end

   // Read-data scoreboard
   initial begin
      forever begin
         @(negedge clk);
         if (rd_valid === 1'b1) begin
            rv_count++;
            checks++;
            if (exp_rd.size() == 0) begin
               errors++; $display("FAIL rd_unexpected got=%h need=none", rd_data);
            end else begin
               mon_exp = exp_rd.pop_front();
               if (rd_data !== mon_exp)
                  begin errors++; $display("FAIL rd_data got=%h need=%h", rd_data, mon_exp); end
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout need=finish");
      $fatal(1);
   end

   // Called at a negedge; returns at the negedge of cycle 0 with t0 = that cycle's index.
   task automatic send(input logic [9:0] c, output int t0);
      int n;
      n = 0;
      while (cmd_ready !== 1'b1 && n < 300) begin @(negedge clk); n++; end
      checks++;
      if (cmd_ready !== 1'b1) begin errors++; $display("FAIL send_ready got=%b need=1", cmd_ready); end
      cmd_valid = 1'b1; cmd_data = c;
      frame_q.push_back(c);
      @(negedge clk);
      cmd_valid = 1'b0; cmd_data = '0;
      t0 = cyc;
   endtask

   task automatic wait_rd(input int rv0);
      int n;
      n = 0;
      while (rv_count == rv0 && n < 80) begin @(negedge clk); n++; end
      checks++;
      if (rv_count == rv0) begin errors++; $display("FAIL rd_timeout got=none need=pulse"); end
   endtask

   task automatic test_reset();
      checks += 7;
      if (ss_n !== 1'b1)      begin errors++; $display("FAIL rst_ss_n got=%b need=1", ss_n); end
      if (mosi !== 1'b0)      begin errors++; $display("FAIL rst_mosi got=%b need=0", mosi); end
      if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got=%b need=1", cmd_ready); end
      if (busy !== 1'b0)      begin errors++; $display("FAIL rst_busy got=%b need=0", busy); end
      if (rd_valid !== 1'b0)  begin errors++; $display("FAIL rst_rd_valid got=%b need=0", rd_valid); end
      if (rd_data !== 8'h00)  begin errors++; $display("FAIL rst_rd_data got=%h need=00", rd_data); end
      if (b_ss_n !== 1'b1)    begin errors++; $display("FAIL rst_b_ss_n got=%b need=1", b_ss_n); end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (cmd_ready !== 1'b1) begin errors++; $display("FAIL post_rst_ready got=%b need=1", cmd_ready); end
   endtask

   task automatic test_wr_addr();
      int t0;
      logic [9:0] c;
      logic em;
      c = {OP_WR_ADDR, 8'hA5};
      send(c, t0);
      for (int r = 0; r <= 13; r++) begin
         if (r > 0) @(negedge clk);
         em = 1'b0;
         if (r == 1) em = c[9];
         else if (r >= 2 && r <= 11) em = c[11 - r];
         checks += 4;
         if (mosi !== em) begin errors++; $display("FAIL wr_mosi c%0d got=%b need=%b", r, mosi, em); end
         if (ss_n !== (r > 11))
            begin errors++; $display("FAIL wr_ss_n c%0d got=%b need=%b", r, ss_n, r > 11); end
         if (cmd_ready !== (r == 13))
            begin errors++; $display("FAIL wr_ready c%0d got=%b need=%b", r, cmd_ready, r == 13); end
         if (busy !== (r != 13))
            begin errors++; $display("FAIL wr_busy c%0d got=%b need=%b", r, busy, r != 13); end
      end
   endtask

   task automatic test_read();
      int t0, pulses, prel;
      pulses = 0; prel = -1;
      slv_ra = 8'h33; slv_mem[8'h33] = 8'hC3;
      exp_rd.push_back(8'hC3);
      send({OP_RD_DATA, 8'h00}, t0);
      for (int r = 1; r <= 30; r++) begin
         @(negedge clk);
         if (rd_valid === 1'b1) begin pulses++; prel = r; end
         checks++;
         if (cmd_ready !== (r >= 20 + RD_LAT))
            begin errors++; $display("FAIL rd_ready c%0d got=%b need=%b", r, cmd_ready, r >= 20 + RD_LAT); end
      end
      checks += 3;
      if (pulses != 1) begin errors++; $display("FAIL rd_pulses got=%0d need=1", pulses); end
      if (prel != 19 + RD_LAT) begin errors++; $display("FAIL rd_cycle got=%0d need=%0d", prel, 19 + RD_LAT); end
      if (rd_data !== 8'hC3) begin errors++; $display("FAIL rd_hold got=%h need=c3", rd_data); end
   endtask

   task automatic test_reset_mid();
      int t0, rv0;
      rv0 = rv_count;
      send({OP_RD_DATA, 8'h00}, t0);
      repeat (8) @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks += 3;
      if (ss_n !== 1'b1)     begin errors++; $display("FAIL mid_ss_n got=%b need=1", ss_n); end
      if (rd_data !== 8'h00) begin errors++; $display("FAIL mid_rd_data got=%h need=00", rd_data); end
      if (busy !== 1'b0)     begin errors++; $display("FAIL mid_busy got=%b need=0", busy); end
      @(negedge clk);
      rst_n = 1'b1;
      frame_q.delete();
      repeat (30) @(negedge clk);
      checks += 2;
      if (rv_count != rv0)   begin errors++; $display("FAIL mid_rd_valid got=%0d need=0", rv_count - rv0); end
      if (rd_data !== 8'h00) begin errors++; $display("FAIL mid_rd_clr got=%h need=00", rd_data); end
      slv_mem[8'h33] = 8'h96;
      exp_rd.push_back(8'h96);
      rv0 = rv_count;
      send({OP_RD_DATA, 8'h00}, t0);
      wait_rd(rv0);
      @(negedge clk);
      checks++;
      if (rd_data !== 8'h96) begin errors++; $display("FAIL mid_next got=%h need=96", rd_data); end
   endtask

   task automatic test_closed_loop();
      int t0, rv0;
      send({OP_WR_ADDR, 8'h12}, t0);
      send({OP_WR_DATA, 8'h5A}, t0);
      send({OP_WR_ADDR, 8'h13}, t0);
      send({OP_WR_DATA, 8'hE1}, t0);
      send({OP_RD_ADDR, 8'h12}, t0);
      exp_rd.push_back(8'h5A);
      rv0 = rv_count;
      send({OP_RD_DATA, 8'h00}, t0);
      wait_rd(rv0);
      @(negedge clk);
      checks++;
      if (rd_data !== 8'h5A) begin errors++; $display("FAIL loop_rd got=%h need=5a", rd_data); end
   endtask

   task automatic test_ignore_pulse();
      int t0, falls;
      logic prev;
      falls = 0;
      send({OP_WR_ADDR, 8'h77}, t0);
      repeat (4) @(negedge clk);
      cmd_valid = 1'b1; cmd_data = {OP_RD_DATA, 8'hFF};
      @(negedge clk);
      cmd_valid = 1'b0; cmd_data = '0;
      prev = ss_n;
      repeat (40) begin
         @(negedge clk);
         if (prev === 1'b1 && ss_n === 1'b0) falls++;
         prev = ss_n;
      end
      checks += 3;
      if (falls != 0) begin errors++; $display("FAIL ign_frames got=%0d need=0", falls); end
      if (frame_q.size() != 0) begin errors++; $display("FAIL ign_pending got=%0d need=0", frame_q.size()); end
      if (cmd_ready !== 1'b1) begin errors++; $display("FAIL ign_ready got=%b need=1", cmd_ready); end
   endtask

   task automatic test_back_to_back();
      int starts[2];
      int n, gap_hi, lo;
      logic prev_ready;
      logic ss_tr[64];
      logic busy_tr[64];
      n = 0; gap_hi = 0; lo = 0; starts[0] = 0; starts[1] = 0;
      prev_ready = b_ready;
      b_valid = 1'b1; b_data = {OP_WR_ADDR, 8'h21};
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         ss_tr[i] = b_ss_n; busy_tr[i] = b_busy;
         if (prev_ready === 1'b1 && b_ready === 1'b0) begin
            if (n < 2) starts[n] = i;
            n++;
            if (n == 1) b_data = {OP_WR_DATA, 8'h5C};
            else b_valid = 1'b0;
         end
         prev_ready = b_ready;
      end
      for (int i = starts[0]; i < starts[1]; i++) begin
         if (ss_tr[i] && busy_tr[i]) gap_hi++;
         if (!ss_tr[i]) lo++;
      end
      checks += 5;
      if (n != 2) begin errors++; $display("FAIL b2b_accepts got=%0d need=2", n); end
      if (starts[1] - starts[0] != 15)
         begin errors++; $display("FAIL b2b_period got=%0d need=15", starts[1] - starts[0]); end
      if (gap_hi != 2) begin errors++; $display("FAIL b2b_gap got=%0d need=2", gap_hi); end
      if (lo != 12) begin errors++; $display("FAIL b2b_low got=%0d need=12", lo); end
      if (ss_tr[starts[1]] !== 1'b0)
         begin errors++; $display("FAIL b2b_second got=%b need=0", ss_tr[starts[1]]); end
   endtask

   initial begin
      rst_n = 1'b0;
      cmd_valid = 1'b0; cmd_data = '0;
      b_valid = 1'b0; b_data = '0;
      repeat (3) @(negedge clk);
      test_reset();
      test_wr_addr();
      test_read();
      test_reset_mid();
      test_closed_loop();
      test_ignore_pulse();
      test_back_to_back();
      checks++;
      if (exp_rd.size() != 0) begin errors++; $display("FAIL rd_left got=%0d need=0", exp_rd.size()); end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
